icache_line_fill: RTL and testbench



---
 rtl/icache_line_fill.sv | 144 ++++++++++++++
 tb/tb_icache_line_fill.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Instruction-cache line-fill engine: turns one line request into NWORDS single-word bus reads.
// Define ICACHE_FILL_CWF_EN to fetch the critical word first (the line layout does not change).
module icache_line_fill #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              icache_req_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  output logic [LINE_W-1:0] icache_data_o,
  output logic              icache_ack_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  input  logic [WORD_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              busy_o
);

  localparam int NWORDS  = LINE_W / WORD_W;
  localparam int IDX_W   = $clog2(NWORDS);
  localparam int WBYTES  = WORD_W / 8;
  localparam int OFF_LSB = $clog2(WBYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              bus_req_q, bus_req_d;
  logic              ack_q, ack_d;
  logic              abort_q, abort_d;
  logic              abort_now;
  logic [IDX_W-1:0]  slot;

  function automatic logic [ADDR_W-1:0] beatAddr(input logic [ADDR_W-1:0] base,
                                                 input logic [IDX_W-1:0]  idx);
    return base + ADDR_W'(idx) * ADDR_W'(WBYTES);
  endfunction

  // A dropped request during a burst latches the abort; the word slot comes from the held address.
  assign abort_now = abort_q | ~icache_req_i;
  assign slot      = bus_addr_q[OFF_LSB +: IDX_W];

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    data_d     = data_q;
    bus_req_d  = bus_req_q;
    bus_addr_d = bus_addr_q;
    ack_d      = 1'b0;
    abort_d    = abort_q;

    case (state_q)
      IDLE: begin
        if (icache_req_i) begin
          base_d = icache_addr_i & ~LINE_MASK;
`ifdef ICACHE_FILL_CWF_EN
          start_d = icache_addr_i[OFF_LSB +: IDX_W];
`else
          start_d = '0;
`endif
          cnt_d      = '0;
          abort_d    = 1'b0;
          bus_req_d  = 1'b1;
          bus_addr_d = beatAddr(base_d, start_d);
          state_d    = BURST;
        end
      end
      BURST: begin
        abort_d = abort_now;
        if (bus_req_q) begin
          if (bus_ack_i) begin
            line_d[int'(slot) * WORD_W +: WORD_W] = bus_data_i;
            cnt_d     = cnt_q + 1'b1;
            bus_req_d = 1'b0;
            if (abort_now) begin
              state_d = IDLE;
            end else if (cnt_q == LAST_BEAT) begin
              data_d  = line_d;
              ack_d   = 1'b1;
              state_d = DONE;
            end else begin
              bus_addr_d = beatAddr(base_q, start_q + cnt_d);
            end
          end
        end else if (abort_now) begin
          state_d = IDLE;
        end else begin
          bus_req_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      base_q     <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      data_q     <= '0;
      bus_req_q  <= 1'b0;
      bus_addr_q <= '0;
      ack_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      data_q     <= data_d;
      bus_req_q  <= bus_req_d;
      bus_addr_q <= bus_addr_d;
      ack_q      <= ack_d;
      abort_q    <= abort_d;
    end
  end

  assign icache_data_o = data_q;
  assign icache_ack_o  = ack_q;
  assign bus_req_o     = bus_req_q;
  assign bus_addr_o    = bus_addr_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_icache_line_fill.sv
// Randomised scoreboard bench for icache_line_fill: stimulus queues expected bus addresses and lines,
// a negedge monitor acts as the memory, pops and compares.
module tb_icache_line_fill;

  localparam int NWORDS = 4;

  logic         clk;
  logic         rstN;
  logic         icacheReq;
  logic [31:0]  icacheAddr;
  logic [127:0] icacheData;
  logic         icacheAck;
  logic         busReq;
  logic [31:0]  busAddr;
  logic [31:0]  busData = 32'h0;
  logic         busAck = 1'b0;
  logic         busy;

  icache_line_fill dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .icache_req_i (icacheReq),
    .icache_addr_i(icacheAddr),
    .icache_data_o(icacheData),
    .icache_ack_o (icacheAck),
    .bus_req_o    (busReq),
    .bus_addr_o   (busAddr),
    .bus_data_i   (busData),
    .bus_ack_i    (busAck),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int beatsIssued = 0;
  int ackCount = 0;
  int curDelay = 0;
  int waitCnt = 0;
  bit prevReq = 1'b0;
  bit prevAck = 1'b0;
  bit prevIcAck = 1'b0;
  logic [31:0]  heldAddr = 32'h0;
  logic [31:0]  memData [NWORDS];
  logic [31:0]  expAddrQ [$];
  logic [127:0] expLineQ [$];
  logic [127:0] lastLine = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: line base plus wrapped word offset, independent of any RTL state.
  function automatic logic [31:0] modelBeatAddr(input logic [31:0] addr, input int k);
    logic [31:0] base;
    int start;
    base = addr & 32'hFFFF_FFF0;
`ifdef ICACHE_FILL_CWF_EN
    start = int'(addr[3:2]);
`else
    start = 0;
`endif
    return base + 32'((start + k) % NWORDS) * 32'd4;
  endfunction

  // Memory responder plus monitor: decides bus_ack for the coming edge and checks what the DUT shows.
  always @(negedge clk) begin
    if (!rstN) begin
      prevReq = 1'b0;
      prevAck = 1'b0;
      prevIcAck = 1'b0;
      waitCnt = 0;
      busAck = 1'b0;
    end else begin
      if (busReq) begin
        if (!prevReq) begin
          beatsIssued++;
          waitCnt = 0;
          heldAddr = busAddr;
          checkOutput("bus_beat_expected", expAddrQ.size() > 0, 1'b1);
          if (expAddrQ.size() > 0) checkOutput("bus_addr", busAddr, expAddrQ.pop_front());
        end else if (prevAck) begin
          checkOutput("bus_req_gap", busReq, 1'b0);
        end else begin
          checkOutput("bus_addr_stable", busAddr, heldAddr);
        end
      end
      if (busReq && waitCnt >= curDelay) begin
        busAck = 1'b1;
        busData = memData[busAddr[3:2]];
      end else if (busReq) begin
        busAck = 1'b0;
        busData = $urandom;
        waitCnt++;
      end else begin
        busAck = ($urandom_range(0, 3) == 0);
        busData = $urandom;
      end
      prevReq = busReq;
      prevAck = busReq && busAck;
      if (icacheAck) begin
        ackCount++;
        checkOutput("icache_ack_single_cycle", prevIcAck, 1'b0);
        checkOutput("icache_ack_expected", expLineQ.size() > 0, 1'b1);
        if (expLineQ.size() > 0) checkOutput("icache_line", icacheData, expLineQ.pop_front());
      end
      prevIcAck = icacheAck;
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input int delay, input bit doAbort, output int latency);
    logic [127:0] line;
    int acksBefore;
    int startCyc;
    bit done;
    for (int k = 0; k < (doAbort ? 2 : NWORDS); k++) expAddrQ.push_back(modelBeatAddr(addr, k));
    line = {memData[3], memData[2], memData[1], memData[0]};
    if (!doAbort) expLineQ.push_back(line);
    curDelay = delay;
    acksBefore = ackCount;
    latency = -1;
    @(posedge clk);
    #1;
    beatsIssued = 0;
    icacheReq = 1'b1;
    icacheAddr = addr;
    startCyc = cyc;
    if (doAbort) begin
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(posedge clk);
        done = (beatsIssued >= 2);
      end
      #1 icacheReq = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        done = !busy;
      end
      checkOutput("abort_returns_idle", done, 1'b1);
      checkOutput("abort_no_icache_ack", ackCount - acksBefore, 0);
      checkOutput("abort_line_unchanged", icacheData, lastLine);
    end else begin
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk);
        done = icacheAck;
      end
      checkOutput("fill_ack_seen", done, 1'b1);
      latency = cyc - startCyc;
      @(posedge clk);
      #1 icacheReq = 1'b0;
      lastLine = line;
    end
  endtask

  initial begin
    int lat;
    bit ab;
    bit done;
    int d;
    rstN = 1'b0;
    icacheReq = 1'b0;
    icacheAddr = 32'h0;
    for (int i = 0; i < NWORDS; i++) memData[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_bus_req", busReq, 1'b0);
    checkOutput("reset_bus_addr", busAddr, 32'h0);
    checkOutput("reset_icache_ack", icacheAck, 1'b0);
    checkOutput("reset_icache_data", icacheData, 128'h0);

    // Zero-wait bus: req cycle counts as cycle 1, ack lands in cycle 2*NWORDS+1 = 9.
    for (int i = 0; i < NWORDS; i++) memData[i] = 32'hA0 + 32'(i);
    applyStimulus(32'h0000_1234, 0, 1'b0, lat);
    checkOutput("zero_wait_latency", lat, 2 * NWORDS);
    checkOutput("directed_line_layout", icacheData, 128'h000000A3_000000A2_000000A1_000000A0);

    applyStimulus(32'h0000_1234, 3, 1'b0, lat);

    for (int i = 0; i < NWORDS; i++) memData[i] = $urandom;
    applyStimulus(32'h0000_1234, 2, 1'b1, lat);

    for (int i = 0; i < NWORDS; i++) memData[i] = 32'hA0 + 32'(i);
    applyStimulus(32'h0000_1238, 0, 1'b0, lat);
    checkOutput("wrap_line_layout", icacheData, 128'h000000A3_000000A2_000000A1_000000A0);

    for (int i = 0; i < NWORDS; i++) begin
      memData[i] = $urandom;
      expAddrQ.push_back(modelBeatAddr(32'h0000_3000, i));
    end
    @(posedge clk);
    #1;
    curDelay = 1;
    beatsIssued = 0;
    icacheReq = 1'b1;
    icacheAddr = 32'h0000_3000;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      done = (beatsIssued >= 2);
    end
    #3 rstN = 1'b0;
    icacheReq = 1'b0;
    #1;
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_bus_req", busReq, 1'b0);
    checkOutput("midreset_bus_addr", busAddr, 32'h0);
    checkOutput("midreset_icache_data", icacheData, 128'h0);
    expAddrQ.delete();
    expLineQ.delete();
    lastLine = '0;
    @(posedge clk);
    #1 rstN = 1'b1;
    for (int i = 0; i < NWORDS; i++) memData[i] = $urandom;
    applyStimulus(32'h0000_2000, 0, 1'b0, lat);
    checkOutput("post_reset_latency", lat, 2 * NWORDS);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NWORDS; i++) memData[i] = $urandom;
      ab = ($urandom_range(0, 3) == 0);
      d = ab ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
      applyStimulus($urandom, d, ab, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("addr_queue_drained", expAddrQ.size(), 0);
    checkOutput("line_queue_drained", expLineQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
